// File: rtl/btn_latch_strobe_if.sv
// Signal bundle between the button/switch front end and the D-latch control stage.
// The slave side is the strobe generator; the master side supplies the raw inputs.
interface btn_latch_strobe_if;
    logic btn_in;
    logic d_in;
    logic btn_level;
    logic e_pulse;
    logic rel_pulse;
    logic d_out;

    modport master (
        output btn_in,
        output d_in,
        input  btn_level,
        input  e_pulse,
        input  rel_pulse,
        input  d_out
    );

    modport slave (
        input  btn_in,
        input  d_in,
        output btn_level,
        output e_pulse,
        output rel_pulse,
        output d_out
    );
endinterface

// File: rtl/btn_latch_strobe.sv
// Synchronizes and debounces a raw push-button and data switch, producing the
// d/e drive for the downstream D-latch plus press/release strobes and a clean level.
module btn_latch_strobe #(
    parameter int DB_CYCLES = 50000,
    parameter int CNT_W     = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    btn_latch_strobe_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CHK_HI = 2'd1,
        HIGH   = 2'd2,
        CHK_LO = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic             btn_meta_q, btn_meta_d;
    logic             btn_s_q, btn_s_d;
    logic             d_meta_q, d_meta_d;
    logic             d_s_q, d_s_d;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             e_pulse_q, e_pulse_d;
    logic             rel_pulse_q, rel_pulse_d;
    logic             btn_level_q, btn_level_d;
    logic             d_out_q, d_out_d;

    always_comb begin
        btn_meta_d = bus.btn_in;
        btn_s_d    = btn_meta_q;
        d_meta_d   = bus.d_in;
        d_s_d      = d_meta_q;
    end

    // Only the synchronized copies btn_s_q/d_s_q may steer the FSM.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        e_pulse_d   = 1'b0;
        rel_pulse_d = 1'b0;
        btn_level_d = btn_level_q;
        d_out_d     = d_out_q;

        case (state_q)
            IDLE: begin
                if (btn_s_q) begin
                    state_d = CHK_HI;
                    cnt_d   = '0;
                end
            end
            CHK_HI: begin
                if (!btn_s_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = HIGH;
                    e_pulse_d   = 1'b1;
                    btn_level_d = 1'b1;
                    d_out_d     = d_s_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HIGH: begin
                if (!btn_s_q) begin
                    state_d = CHK_LO;
                    cnt_d   = '0;
                end
            end
            CHK_LO: begin
                if (btn_s_q) begin
                    state_d = HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = IDLE;
                    rel_pulse_d = 1'b1;
                    btn_level_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d     = IDLE;
                cnt_d       = '0;
                btn_level_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_meta_q  <= 1'b0;
            btn_s_q     <= 1'b0;
            d_meta_q    <= 1'b0;
            d_s_q       <= 1'b0;
            state_q     <= IDLE;
            cnt_q       <= '0;
            e_pulse_q   <= 1'b0;
            rel_pulse_q <= 1'b0;
            btn_level_q <= 1'b0;
            d_out_q     <= 1'b0;
        end else begin
            btn_meta_q  <= btn_meta_d;
            btn_s_q     <= btn_s_d;
            d_meta_q    <= d_meta_d;
            d_s_q       <= d_s_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            e_pulse_q   <= e_pulse_d;
            rel_pulse_q <= rel_pulse_d;
            btn_level_q <= btn_level_d;
            d_out_q     <= d_out_d;
        end
    end

    assign bus.btn_level = btn_level_q;
    assign bus.e_pulse   = e_pulse_q;
    assign bus.rel_pulse = rel_pulse_q;
    assign bus.d_out     = d_out_q;

    // Press and release can never be accepted on the same edge.
    strobe_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
        !(e_pulse_q && rel_pulse_q));

endmodule

// File: tb/tb_btn_latch_strobe.sv
// Scoreboard bench for btn_latch_strobe with DB_CYCLES=4: each driven edge
// pushes the strobe it should cause, and a negedge monitor pops and compares.
module tb_btn_latch_strobe;

   localparam int DB  = 4;
   localparam int LAT = DB + 3;

   typedef struct {
      bit   isPress;
      int   cycle;
      logic dOut;
      logic level;
   } strobeEvent_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   errCount = 0;
   int   checkCount = 0;
   strobeEvent_t sbQ[$];

   btn_latch_strobe_if bus();

   btn_latch_strobe #(.DB_CYCLES(DB), .CNT_W(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // 10 ns clock; cyc counts rising edges so expectations can be stated as edge numbers
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Every comparison in the bench funnels through here
   task automatic checkOutput(input string tag, input int actual, input int expected);
      checkCount++;
      if (actual !== expected) begin
         errCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", tag, actual, expected, cyc);
      end
   endtask

   // Drive raw inputs at a negedge and hold them for a number of cycles
   task automatic applyStimulus(input logic btn, input logic d, input int hold);
      bus.btn_in = btn;
      bus.d_in   = d;
      repeat (hold) @(negedge clk);
   endtask

   // Record a strobe due LAT edges after the input change driven right now
   task automatic expectStrobe(input bit isPress, input logic dOut, input logic level);
      strobeEvent_t ev;
      ev.isPress = isPress;
      ev.cycle   = cyc + LAT;
      ev.dOut    = dOut;
      ev.level   = level;
      sbQ.push_back(ev);
   endtask

   // Monitor: any strobe must match the oldest pending expectation
   always @(negedge clk) begin
      strobeEvent_t ev;
      if (rst_n && (bus.e_pulse || bus.rel_pulse)) begin
         checkOutput("strobe_exclusive", int'(bus.e_pulse & bus.rel_pulse), 0);
         if (sbQ.size() == 0) begin
            checkOutput("unexpected_strobe", 1, 0);
         end else begin
            ev = sbQ.pop_front();
            checkOutput("strobe_kind_is_press", int'(bus.e_pulse), int'(ev.isPress));
            checkOutput("strobe_cycle", cyc, ev.cycle);
            checkOutput("strobe_d_out", int'(bus.d_out), int'(ev.dOut));
            checkOutput("strobe_btn_level", int'(bus.btn_level), int'(ev.level));
         end
      end
   end

   initial begin
      bus.btn_in = 1'b0;
      bus.d_in   = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("reset_btn_level", int'(bus.btn_level), 0);
      checkOutput("reset_e_pulse", int'(bus.e_pulse), 0);
      checkOutput("reset_rel_pulse", int'(bus.rel_pulse), 0);
      checkOutput("reset_d_out", int'(bus.d_out), 0);
      rst_n = 1'b1;
      applyStimulus(1'b0, 1'b1, 4);

      $display("[TB] clean press");
      expectStrobe(1'b1, 1'b1, 1'b1);
      applyStimulus(1'b1, 1'b1, LAT + 5);
      checkOutput("press_level", int'(bus.btn_level), 1);
      checkOutput("press_d_out", int'(bus.d_out), 1);

      $display("[TB] release");
      expectStrobe(1'b0, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b1, LAT + 5);
      checkOutput("release_level", int'(bus.btn_level), 0);
      checkOutput("release_d_out", int'(bus.d_out), 1);

      $display("[TB] bounce reject");
      applyStimulus(1'b1, 1'b1, 3);
      applyStimulus(1'b0, 1'b1, 2);
      checkOutput("bounce_level", int'(bus.btn_level), 0);
      expectStrobe(1'b1, 1'b1, 1'b1);
      applyStimulus(1'b1, 1'b1, LAT + 5);
      checkOutput("bounce_press_level", int'(bus.btn_level), 1);

      $display("[TB] release bounce");
      applyStimulus(1'b0, 1'b1, 2);
      for (int i = 0; i < 10; i++) begin
         bus.btn_in = 1'b1;
         @(negedge clk);
         checkOutput("rel_bounce_level", int'(bus.btn_level), 1);
      end

      expectStrobe(1'b0, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b1, LAT + 5);

      $display("[TB] data hold");
      applyStimulus(1'b0, 1'b0, 4);
      expectStrobe(1'b1, 1'b0, 1'b1);
      applyStimulus(1'b1, 1'b0, LAT + 3);
      checkOutput("hold_d_out_first", int'(bus.d_out), 0);
      applyStimulus(1'b1, 1'b1, 10);
      checkOutput("hold_d_out_toggled", int'(bus.d_out), 0);
      expectStrobe(1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1, LAT + 5);
      checkOutput("idle_d_out", int'(bus.d_out), 0);
      expectStrobe(1'b1, 1'b1, 1'b1);
      applyStimulus(1'b1, 1'b1, LAT + 5);
      checkOutput("second_press_d_out", int'(bus.d_out), 1);
      expectStrobe(1'b0, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b1, LAT + 5);

      $display("[TB] async reset mid-qualification");
      applyStimulus(1'b1, 1'b1, 5);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("async_btn_level", int'(bus.btn_level), 0);
      checkOutput("async_e_pulse", int'(bus.e_pulse), 0);
      checkOutput("async_rel_pulse", int'(bus.rel_pulse), 0);
      checkOutput("async_d_out", int'(bus.d_out), 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      expectStrobe(1'b1, 1'b1, 1'b1);
      applyStimulus(1'b1, 1'b1, LAT + 5);
      checkOutput("post_reset_level", int'(bus.btn_level), 1);

      // Bounded drain of anything the DUT still owes
      for (int i = 0; i < 20 && sbQ.size() != 0; i++) @(negedge clk);
      checkOutput("pending_strobes", sbQ.size(), 0);

      $display("Result: errors=%0d of %0d checks", errCount, checkCount);
      $finish;
   end

   // Hard stop if the stimulus sequence ever stalls
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/btn_latch_strobe.md
Name: btn_latch_strobe

Overview:
- Upstream control stage for the D-latch datapath. Cleans a raw push-button and a raw data switch, then produces a data bit and an enable strobe (`d_out`, `e_pulse`) that drive the latch's `d` and `e` inputs directly.
- Contains a 2-flop synchronizer, a debounce counter and a 4-state FSM.
- Emits one-cycle press and release strobes plus a clean level.

Parameters:
- DB_CYCLES, 50000, consecutive stable synchronized samples needed to accept a change; legal range 2..2^CNT_W-1.
- CNT_W, 16, debounce counter width.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  reset, asynchronous, active-low.
- btn_in  input  1  raw asynchronous push-button (bouncy).
- d_in  input  1  raw data switch, quasi-static.
- btn_level  output  1  debounced button level.
- e_pulse  output  1  one-cycle strobe on accepted press; drives latch `e`.
- rel_pulse  output  1  one-cycle strobe on accepted release.
- d_out  output  1  data bit captured at accepted press; drives latch `d`.

Behaviour:
- Clock and reset: one clock, `clk`. Reset `rst_n` is asynchronous, active-low.
- Reset values:
  - All flops clear: sync stages=0, cnt=0, state=IDLE.
  - Outputs: `btn_level`=0, `e_pulse`=0, `rel_pulse`=0, `d_out`=0.
- Synchronizer:
  - `btn_in` and `d_in` each pass through 2 flops to give `btn_s` and `d_s`.
  - All FSM decisions use `btn_s` and `d_s` only.
- FSM states: IDLE, CHK_HI, HIGH, CHK_LO.
  - IDLE: if `btn_s`=1, go to CHK_HI with cnt<=0. Otherwise stay.
  - CHK_HI:
    - If `btn_s`=0, return to IDLE with cnt<=0.
    - Else if cnt==DB_CYCLES-1, go to HIGH. On the same edge: `e_pulse`<=1, `btn_level`<=1, `d_out`<=`d_s`.
    - Else cnt<=cnt+1.
  - HIGH: if `btn_s`=0, go to CHK_LO with cnt<=0.
  - CHK_LO:
    - If `btn_s`=1, return to HIGH with cnt<=0, and no strobe.
    - Else if cnt==DB_CYCLES-1, go to IDLE. On the same edge: `rel_pulse`<=1, `btn_level`<=0.
    - Else cnt<=cnt+1.
- Strobes: `e_pulse` and `rel_pulse` are registered, exactly one cycle wide, and never both high.
- Latency: with `btn_in` rising before edge 1 and held stable, `e_pulse` and `btn_level` rise after edge DB_CYCLES+3. Release is symmetric, with `rel_pulse` rising after edge DB_CYCLES+3.
- Glitches:
  - Any bounce inside CHK_HI or CHK_LO restarts the qualification from the stable state.
  - A bounce shorter than DB_CYCLES+1 synchronized samples produces no strobe and no change to `btn_level`.
- `d_out` holds its value between presses. Changes to `d_in` while the button is held or idle have no effect on `d_out`.
- Counter: saturation is never reached because the compare-and-exit happens at DB_CYCLES-1. It uses unsigned compare at CNT_W bits.
- Reset mid-operation: asserting `rst_n` low in any state immediately (asynchronously) clears all outputs and returns to IDLE. A pending strobe is discarded. After release, a still-held button must re-qualify from IDLE.
- No other states are reachable. Illegal state encodings recover to IDLE on the next edge.

Test Plan (DB_CYCLES=4, 10 ns clock):
- Clean press: `d_in`=1, then `btn_in` 0->1 held.
  - Required: `e_pulse`=1 for exactly one cycle after edge 7, `btn_level`=1 from then on, `d_out`=1.
- Bounce reject: `btn_in` high for 3 cycles, low for 2, then high and held.
  - Required: no `e_pulse` during the bounce.
  - Required: `e_pulse` after edge 7 counted from the final rise; exactly one strobe in total.
- Release: from HIGH, `btn_in` 1->0 held.
  - Required: `rel_pulse` one cycle after edge 7, `btn_level`=0, `d_out` unchanged, `e_pulse` stays 0.
- Release bounce: from HIGH, `btn_in` low for 2 cycles then high.
  - Required: FSM returns to HIGH, `btn_level` stays 1, no `rel_pulse`.
- Data hold: press with `d_in`=0, then toggle `d_in` 0->1 while held, release, then press again with `d_in`=1.
  - Required: `d_out` is 0 through the first hold and becomes 1 only at the second `e_pulse`.
- Async reset: assert `rst_n`=0 mid-CHK_HI (cnt=2), asynchronously, between clock edges.
  - Required: all outputs are 0 immediately.
  - Required: after `rst_n`=1 with the button still held, `e_pulse` occurs DB_CYCLES+1 edges after `btn_s` is seen high in IDLE, and not earlier.
